// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches one W_BUS-bit word and sends it as N_WORDS framed characters, word 0 first.
// Optional even parity in bit BITS_PER_WORD+1 of each character when UART_TX_PARITY_EN is defined.
//
// state | meaning
// IDLE  | line high, s_ready=1, waiting for s_valid
// SEND  | shifting characters onto tx, inputs ignored
module uart_tx_serializer #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_BUS            = 40,
  parameter int PACKET_SIZE      = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W_BUS-1:0] s_data,
  output logic             tx,
  output logic             busy
);

  localparam int N_WORDS = W_BUS / BITS_PER_WORD;
  localparam int PULSE_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BIT_W   = $clog2(PACKET_SIZE);
  localparam int WORD_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(PACKET_SIZE - 1);
  localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(N_WORDS - 1);

  if (W_BUS % BITS_PER_WORD != 0) begin : g_bad_bus
    $error("W_BUS must be a multiple of BITS_PER_WORD");
  end
  if (PACKET_SIZE < BITS_PER_WORD + 2) begin : g_bad_packet
    $error("PACKET_SIZE must be at least BITS_PER_WORD+2");
  end
`ifdef UART_TX_PARITY_EN
  if (PACKET_SIZE < BITS_PER_WORD + 3) begin : g_bad_parity
    $error("parity needs PACKET_SIZE of at least BITS_PER_WORD+3");
  end
`endif

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state_q, state_n;
  logic [W_BUS-1:0]    shift_q, shift_n;
  logic [WORD_W-1:0]   word_q, word_n;
  logic [BIT_W-1:0]    bit_q, bit_n;
  logic [PULSE_W-1:0]  pulse_q, pulse_n;
  logic                tx_q, tx_n;
  logic                busy_q;
  logic [BITS_PER_WORD-1:0] cur_char;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      pulse_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      word_q  <= word_n;
      bit_q   <= bit_n;
      pulse_q <= pulse_n;
      tx_q    <= tx_n;
      busy_q  <= (state_n == SEND);
    end
  end

  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    word_n  = word_q;
    bit_n   = bit_q;
    pulse_n = pulse_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_n = SEND;
          shift_n = s_data;
          word_n  = '0;
          bit_n   = '0;
          pulse_n = '0;
        end
      end
      SEND: begin
        if (pulse_q == PULSE_LAST) begin
          pulse_n = '0;
          if (bit_q == BIT_LAST) begin
            bit_n = '0;
            if (word_q == WORD_LAST) begin
              state_n = IDLE;
              word_n  = '0;
            end else begin
              word_n  = word_q + 1'b1;
              shift_n = shift_q >> BITS_PER_WORD;
            end
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end else begin
          pulse_n = pulse_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // tx is computed from next-state counters so the registered pad output lines up with the bit slot
  always_comb begin
    cur_char = shift_n[BITS_PER_WORD-1:0];
    tx_n     = 1'b1;
    if (state_n == SEND) begin
      if (bit_n == '0) tx_n = 1'b0;
      for (int i = 0; i < BITS_PER_WORD; i++) begin
        if (bit_n == BIT_W'(i + 1)) tx_n = cur_char[i];
      end
`ifdef UART_TX_PARITY_EN
      if (bit_n == BIT_W'(BITS_PER_WORD + 1)) tx_n = ^cur_char;
`endif
    end
  end

  assign s_ready = (state_q == IDLE);
  assign tx      = tx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized self-checking bench for uart_tx_serializer; expected line levels come from a
// frame-arithmetic model, plus a mid-bit decoder that rebuilds each transmitted word.
module tb_uart_tx_serializer;

  localparam int CPP  = 4;
  localparam int BPW  = 8;
  localparam int WB   = 40;
  localparam int PS   = 13;
  localparam int NW   = WB / BPW;
  localparam int PKT  = NW * PS * CPP;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR9_EXP   = 1'b0;
  localparam int   FIRST_STOP = BPW + 2;
`else
  localparam logic PAR9_EXP   = 1'b1;
  localparam int   FIRST_STOP = BPW + 1;
`endif

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [WB-1:0] s_data;
  logic          tx;
  logic          busy;

  int   n_checks = 0;
  int   n_errors = 0;
  logic wave [PKT];

  uart_tx_serializer #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD(BPW),
    .W_BUS(WB),
    .PACKET_SIZE(PS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .tx(tx),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level k cycles after the handshake edge.
  function automatic logic exp_bit(input logic [WB-1:0] d, input int k);
    int w;
    int b;
    logic [BPW-1:0] c;
    w = k / (PS * CPP);
    b = (k / CPP) % PS;
    c = BPW'(d >> (w * BPW));
    if (b == 0) return 1'b0;
    if (b <= BPW) return c[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == BPW + 1) return ^c;
`endif
    return 1'b1;
  endfunction

  function automatic logic [WB-1:0] rand_word();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_ready", s_ready, 1'b1);
    end
  endtask

  // Starts at a negedge in IDLE. mode 0: quiet inputs, 1: random noise on s_valid/s_data,
  // 2: hold s_valid with nxt for a back-to-back follow-on. abort_k >= 0 resets at that cycle.
  task automatic run_packet(input logic [WB-1:0] d, input int mode,
                            input logic [WB-1:0] nxt, input int abort_k);
    logic [WB-1:0] dec;
    logic          stop_ok;
    s_valid = 1'b1;
    s_data  = d;
    check("ready_before", s_ready, 1'b1);
    for (int k = 0; k < PKT; k++) begin
      @(negedge clk);
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_ready", s_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      wave[k] = tx;
      check("tx", tx, exp_bit(d, k));
      check("busy", busy, 1'b1);
      check("s_ready", s_ready, 1'b0);
      case (mode)
        1: begin
          s_valid = 1'($urandom_range(0, 1));
          s_data  = rand_word();
        end
        2: begin
          s_valid = 1'b1;
          s_data  = nxt;
        end
        default: s_valid = 1'b0;
      endcase
    end
    @(negedge clk);
    check("end_tx", tx, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_ready", s_ready, 1'b1);
    if (mode != 2) s_valid = 1'b0;
    dec     = '0;
    stop_ok = 1'b1;
    for (int w = 0; w < NW; w++) begin
      for (int i = 0; i < BPW; i++)
        dec[w*BPW+i] = wave[(w*PS + i + 1)*CPP + CPP/2];
      for (int b = FIRST_STOP; b < PS; b++)
        stop_ok &= wave[(w*PS + b)*CPP + CPP/2];
    end
    check("decode", dec, d);
    check("stop_bits", stop_ok, 1'b1);
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", s_ready, 1'b1);
    rst = 1'b0;
    idle_gap(2);

    run_packet(40'h00_00_00_00_A5, 0, '0, -1);
    check("a5_bit1", wave[1*CPP+1], 1'b1);
    check("a5_bit2", wave[2*CPP+1], 1'b0);
    check("a5_w1_start", wave[PS*CPP+1], 1'b0);
    idle_gap(5);

    run_packet(40'h1, 2, 40'h2, -1);
    run_packet(40'h2, 0, '0, -1);
    idle_gap(3);

    run_packet(rand_word(), 1, '0, -1);
    idle_gap(20);

    run_packet(rand_word(), 0, '0, 2*PS*CPP + 5*CPP + 1);
    idle_gap(2);
    run_packet(rand_word(), 0, '0, -1);
    idle_gap(2);

    run_packet(40'h03, 0, '0, -1);
    check("parity_bit9", wave[9*CPP+1], PAR9_EXP);

    for (int n = 0; n < 10; n++) begin
      idle_gap($urandom_range(1, 100));
      run_packet(rand_word(), 0, '0, -1);
    end
    idle_gap(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
